// File: rtl/writeback_stage_pkg.sv
// Shared types and constants for the writeback stage: FSM states, special
// register indices and active-low strobe levels.
package wb_pkg;

    typedef enum logic [1:0] {
        WB_IDLE     = 2'd0,
        WB_WAIT_MEM = 2'd1,
        WB_COMMIT   = 2'd2
    } wb_state_t;

    localparam int REG_IH  = 8;
    localparam int REG_SP  = 9;
    localparam int REG_RA  = 10;
    localparam int REG_MAX = REG_RA;

    localparam logic WE_ON  = 1'b0;
    localparam logic WE_OFF = 1'b1;

endpackage

// File: rtl/writeback_stage_if.sv
// Retiring-instruction handshake from the memory stage into writeback.
// A transfer happens on a rising clock edge where inValid and inReady are both high.
interface writeback_stage_if #(
    parameter int DATA_W = 16,
    parameter int IDX_W  = 4
) ();
    logic              inValid;
    logic              inReady;
    logic              inRegWrite;
    logic [IDX_W-1:0]  inRegIndex;
    logic [DATA_W-1:0] inAluResult;
    logic              inIsLoad;
    logic              inTWrite;
    logic              inTValue;

    modport master (
        output inValid, inRegWrite, inRegIndex, inAluResult, inIsLoad, inTWrite, inTValue,
        input  inReady
    );

    modport slave (
        input  inValid, inRegWrite, inRegIndex, inAluResult, inIsLoad, inTWrite, inTValue,
        output inReady
    );
endinterface

// File: rtl/writeback_stage_load_timer.sv
// Load wait counter: clear restarts at zero, enable counts up, expired at MEM_TIMEOUT-1.
// Latency: count updates one cycle after clear/enable; expired is combinational from count.
// Backpressure: none.
module wb_load_timer #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + CNT_W'(1);
        end
    end

    assign expired = (count == CNT_W'(MEM_TIMEOUT - 1));

endmodule

// File: rtl/writeback_stage.sv
// Writeback: sole writer of register file and T flag; optional forwarding under WB_FORWARD_EN.
// Latency: ALU result commits 1 cycle after accept; load commits 1 cycle after ramDataValid.
// Backpressure: inReady low while waiting for load data; a load abandoned after MEM_TIMEOUT.
module writeback_stage
    import wb_pkg::*;
#(
    parameter int DATA_W      = 16,
    parameter int IDX_W       = 4,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    writeback_stage_if.slave  in_bus,
    input  logic [DATA_W-1:0] ramData,
    input  logic              ramDataValid,
    output logic              writeEnable,
    output logic [IDX_W-1:0]  writeIndex,
    output logic [DATA_W-1:0] dataToWrite,
    output logic              tWriteEnable,
    output logic              tToWrite,
    output logic              loadTimeout,
    output logic              badIndex
`ifdef WB_FORWARD_EN
    ,
    output logic              fwdValid,
    output logic [IDX_W-1:0]  fwdIndex,
    output logic [DATA_W-1:0] fwdData
`endif
);

    wb_state_t state, next_state;

    logic accept;
    logic timer_clr, timer_en, timer_expired;
    logic timeout_now, load_done, commit_alu, commit_now;

    // Load instruction fields held while waiting for SRAM data
    logic              pend_reg_write;
    logic [IDX_W-1:0]  pend_index;
    logic              pend_t_write;
    logic              pend_t_value;

    logic              c_reg_write;
    logic [IDX_W-1:0]  c_index;
    logic              c_t_write;
    logic              c_t_value;
    logic [DATA_W-1:0] c_data;
    logic              c_idx_ok;

    assign in_bus.inReady = (state == WB_IDLE) || (state == WB_COMMIT);
    assign accept         = in_bus.inValid && in_bus.inReady;
    assign commit_alu     = accept && !in_bus.inIsLoad;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= WB_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state  = state;
        timer_clr   = 1'b0;
        timer_en    = 1'b0;
        timeout_now = 1'b0;
        load_done   = 1'b0;
        case (state)
            WB_IDLE, WB_COMMIT: begin
                if (accept) begin
                    next_state = in_bus.inIsLoad ? WB_WAIT_MEM : WB_COMMIT;
                    timer_clr  = in_bus.inIsLoad;
                end else begin
                    next_state = WB_IDLE;
                end
            end
            WB_WAIT_MEM: begin
                if (ramDataValid) begin
                    load_done  = 1'b1;
                    next_state = WB_COMMIT;
                end else if (timer_expired) begin
                    timeout_now = 1'b1;
                    next_state  = WB_IDLE;
                end else begin
                    timer_en = 1'b1;
                end
            end
            default: next_state = WB_IDLE;
        endcase
    end

    wb_load_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (timer_clr),
        .enable  (timer_en),
        .expired (timer_expired)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend_reg_write <= 1'b0;
            pend_index     <= '0;
            pend_t_write   <= 1'b0;
            pend_t_value   <= 1'b0;
        end else if (accept) begin
            pend_reg_write <= in_bus.inRegWrite;
            pend_index     <= in_bus.inRegIndex;
            pend_t_write   <= in_bus.inTWrite;
            pend_t_value   <= in_bus.inTValue;
        end
    end

    // A commit comes either straight from an accepted ALU op or from returning load data
    assign commit_now  = commit_alu || load_done;
    assign c_reg_write = commit_alu ? in_bus.inRegWrite  : pend_reg_write;
    assign c_index     = commit_alu ? in_bus.inRegIndex  : pend_index;
    assign c_t_write   = commit_alu ? in_bus.inTWrite    : pend_t_write;
    assign c_t_value   = commit_alu ? in_bus.inTValue    : pend_t_value;
    assign c_data      = commit_alu ? in_bus.inAluResult : ramData;
    assign c_idx_ok    = (c_index <= IDX_W'(REG_MAX));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            writeEnable  <= WE_OFF;
            tWriteEnable <= WE_OFF;
            writeIndex   <= '0;
            dataToWrite  <= '0;
            tToWrite     <= 1'b0;
            loadTimeout  <= 1'b0;
            badIndex     <= 1'b0;
        end else begin
            writeEnable  <= WE_OFF;
            tWriteEnable <= WE_OFF;
            badIndex     <= 1'b0;
            loadTimeout  <= timeout_now;
            if (commit_now) begin
                writeEnable  <= (c_reg_write && c_idx_ok) ? WE_ON : WE_OFF;
                tWriteEnable <= c_t_write ? WE_ON : WE_OFF;
                badIndex     <= c_reg_write && !c_idx_ok;
                writeIndex   <= c_index;
                dataToWrite  <= c_data;
                tToWrite     <= c_t_value;
            end
        end
    end

`ifdef WB_FORWARD_EN
    assign fwdValid = (state == WB_COMMIT) && (writeEnable == WE_ON);
    assign fwdIndex = writeIndex;
    assign fwdData  = dataToWrite;
`endif

endmodule
